// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory load/store against an internal word RAM,
// followed by the MEM/WB pipeline register. Multi-cycle memory latency is
// supported through a two-state FSM that raises MemBusy_Out to stall upstream.
//
// Handshake: an instruction is taken on any rising edge where Valid_In=1 and
// the stage is in IDLE. While MemBusy_Out=1 the stage ignores every input
// and upstream must hold its outputs; the first IDLE edge after completion
// accepts the next instruction with no extra bubble.
module mem_stage #(
  parameter int DEPTH_LOG2  = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Valid_In,
  input  logic [31:0] ALUResult_In,
  input  logic [31:0] WriteData_In,
  input  logic [4:0]  WriteReg_In,
  input  logic [1:0]  MemControl_In,
  input  logic [1:0]  WBControl_In,
  output logic [31:0] Address_Out,
  output logic [31:0] Data_Out,
  output logic [4:0]  WriteReg_Out,
  output logic [1:0]  WBControl_Out,
  output logic        Valid_Out,
  output logic        MemBusy_Out,
  output logic        Misaligned_Out,
  output logic        State_Out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam bit MULTI = (MEM_LATENCY > 1);
  localparam int CW    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [CW-1:0] cnt;
  logic [31:0]   ram [DEPTH];

  // Instruction captured at acceptance of a multi-cycle access
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [4:0]  l_wreg;
  logic [1:0]  l_mc;
  logic [1:0]  l_wb;

  // The operation being finished this edge: latched copy in ACCESS, live inputs otherwise
  logic                  in_access;
  logic [31:0]           c_addr;
  logic [31:0]           c_wdata;
  logic [4:0]            c_wreg;
  logic [1:0]            c_mc;
  logic [1:0]            c_wb;
  logic                  c_req;
  logic                  c_mis;
  logic                  c_mem_ok;
  logic                  c_wr;
  logic                  c_rd;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic                  accept;
  logic                  complete;
  logic                  ram_we;

  // Select operands and decode what happens on the coming edge
  always_comb begin
    in_access = (state == ACCESS);
    c_addr    = in_access ? l_addr  : ALUResult_In;
    c_wdata   = in_access ? l_wdata : WriteData_In;
    c_wreg    = in_access ? l_wreg  : WriteReg_In;
    c_mc      = in_access ? l_mc    : MemControl_In;
    c_wb      = in_access ? l_wb    : WBControl_In;
    c_req     = |c_mc;
    c_mis     = (c_addr[1:0] != 2'b00);
    c_mem_ok  = c_req & ~c_mis;
    // MemRead together with MemWrite behaves as a plain store
    c_wr      = c_mem_ok & c_mc[0];
    c_rd      = c_mem_ok & c_mc[1] & ~c_mc[0];
    c_idx     = c_addr[DEPTH_LOG2+1:2];
    accept    = ~in_access & Valid_In & MULTI & c_mem_ok;
    complete  = in_access ? (cnt == CNT_ONE) : (Valid_In & ~accept);
    ram_we    = c_wr & complete;
  end

  // FSM state register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state and the combinational stall/debug outputs
  always_comb begin
    state_next  = state;
    MemBusy_Out = 1'b0;
    State_Out   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = ACCESS;
      end
      ACCESS: begin
        MemBusy_Out = MULTI;
        State_Out   = 1'b1;
        if (cnt == CNT_ONE) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latency counter: loaded on acceptance, counts down while in ACCESS
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)            cnt <= '0;
    else if (accept)    cnt <= CNT_LOAD;
    else if (in_access) cnt <= cnt - CNT_ONE;
  end

  // Hold the accepted instruction for the duration of a multi-cycle access
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      l_addr  <= '0;
      l_wdata <= '0;
      l_wreg  <= '0;
      l_mc    <= '0;
      l_wb    <= '0;
    end else if (accept) begin
      l_addr  <= ALUResult_In;
      l_wdata <= WriteData_In;
      l_wreg  <= WriteReg_In;
      l_mc    <= MemControl_In;
      l_wb    <= WBControl_In;
    end
  end

  // RAM write port: a store commits only on its completion edge, never under reset
  always_ff @(posedge Clk or posedge Rst) begin
    if (!Rst) begin
      if (ram_we) ram[c_idx] <= c_wdata;
    end
  end

  // MEM/WB pipeline register; a load returns the word as it was before this edge
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Address_Out    <= '0;
      Data_Out       <= '0;
      WriteReg_Out   <= '0;
      WBControl_Out  <= '0;
      Valid_Out      <= 1'b0;
      Misaligned_Out <= 1'b0;
    end else if (complete) begin
      Address_Out    <= c_addr;
      WriteReg_Out   <= c_wreg;
      Valid_Out      <= 1'b1;
      Misaligned_Out <= c_req & c_mis;
      // A suppressed access must not write the register file
      WBControl_Out  <= (c_req & c_mis) ? {c_wb[1], 1'b0} : c_wb;
      Data_Out       <= c_rd ? ram[c_idx] : 32'd0;
    end else if (!in_access) begin
      // Empty slot or acceptance bubble
      Valid_Out      <= 1'b0;
      WBControl_Out  <= 2'b00;
      Misaligned_Out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: one instance with single-cycle memory (index 0) and one
// with a three-cycle memory (index 1), each checked every cycle against a
// transaction-level model, plus literal checks of the directed scenarios.
module tb_mem_stage;

  logic clk;
  logic rst;

  logic        valid_in [2];
  logic [31:0] alu_in   [2];
  logic [31:0] wd_in    [2];
  logic [4:0]  wreg_in  [2];
  logic [1:0]  mc_in    [2];
  logic [1:0]  wb_in    [2];

  logic [31:0] addr_o  [2];
  logic [31:0] data_o  [2];
  logic [4:0]  wreg_o  [2];
  logic [1:0]  wb_o    [2];
  logic        valid_o [2];
  logic        busy_o  [2];
  logic        mis_o   [2];
  logic        st_o    [2];

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  mem_stage #(.DEPTH_LOG2(8), .MEM_LATENCY(1)) u_lat1 (
    .Clk(clk), .Rst(rst), .Valid_In(valid_in[0]), .ALUResult_In(alu_in[0]),
    .WriteData_In(wd_in[0]), .WriteReg_In(wreg_in[0]), .MemControl_In(mc_in[0]),
    .WBControl_In(wb_in[0]), .Address_Out(addr_o[0]), .Data_Out(data_o[0]),
    .WriteReg_Out(wreg_o[0]), .WBControl_Out(wb_o[0]), .Valid_Out(valid_o[0]),
    .MemBusy_Out(busy_o[0]), .Misaligned_Out(mis_o[0]), .State_Out(st_o[0])
  );

  mem_stage #(.DEPTH_LOG2(8), .MEM_LATENCY(3)) u_lat3 (
    .Clk(clk), .Rst(rst), .Valid_In(valid_in[1]), .ALUResult_In(alu_in[1]),
    .WriteData_In(wd_in[1]), .WriteReg_In(wreg_in[1]), .MemControl_In(mc_in[1]),
    .WBControl_In(wb_in[1]), .Address_Out(addr_o[1]), .Data_Out(data_o[1]),
    .WriteReg_Out(wreg_o[1]), .WBControl_Out(wb_o[1]), .Valid_Out(valid_o[1]),
    .MemBusy_Out(busy_o[1]), .Misaligned_Out(mis_o[1]), .State_Out(st_o[1])
  );

  // ---------------- reference model ----------------
  // Each instruction either retires on the edge it is taken, or (aligned memory
  // access with latency L>1) retires L-1 edges later, the instance being deaf
  // to its inputs in between.
  logic [31:0] mram [2][256];
  logic [31:0] e_addr  [2];
  logic [31:0] e_data  [2];
  logic [4:0]  e_wreg  [2];
  logic [1:0]  e_wb    [2];
  logic        e_valid [2];
  logic        e_mis   [2];
  int          wait_left [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wd   [2];
  logic [4:0]  p_wreg [2];
  logic [1:0]  p_mc   [2];
  logic [1:0]  p_wb   [2];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic retire(input int d, input logic [31:0] a, input logic [31:0] wdat,
                        input logic [4:0] r, input logic [1:0] mc, input logic [1:0] wb);
    logic [7:0] idx;
    idx        = a[9:2];
    e_addr[d]  = a;
    e_wreg[d]  = r;
    e_valid[d] = 1'b1;
    if (mc != 2'b00 && (a % 4) != 0) begin
      e_mis[d]  = 1'b1;
      e_wb[d]   = {wb[1], 1'b0};
      e_data[d] = 32'd0;
    end else begin
      e_mis[d] = 1'b0;
      e_wb[d]  = wb;
      if (mc[0]) begin
        mram[d][idx] = wdat;
        e_data[d]    = 32'd0;
      end else if (mc[1]) begin
        e_data[d] = mram[d][idx];
      end else begin
        e_data[d] = 32'd0;
      end
    end
  endtask

  task automatic model_step(input int d);
    if (rst) begin
      e_addr[d] = '0; e_data[d] = '0; e_wreg[d] = '0; e_wb[d] = '0;
      e_valid[d] = 1'b0; e_mis[d] = 1'b0; wait_left[d] = 0;
    end else if (wait_left[d] > 0) begin
      wait_left[d] = wait_left[d] - 1;
      if (wait_left[d] == 0) retire(d, p_addr[d], p_wd[d], p_wreg[d], p_mc[d], p_wb[d]);
    end else if (valid_in[d]) begin
      if (mc_in[d] != 2'b00 && alu_in[d][1:0] == 2'b00 && lat_of(d) > 1) begin
        p_addr[d] = alu_in[d]; p_wd[d] = wd_in[d]; p_wreg[d] = wreg_in[d];
        p_mc[d] = mc_in[d]; p_wb[d] = wb_in[d];
        wait_left[d] = lat_of(d) - 1;
        e_valid[d] = 1'b0; e_wb[d] = 2'b00; e_mis[d] = 1'b0;
      end else begin
        retire(d, alu_in[d], wd_in[d], wreg_in[d], mc_in[d], wb_in[d]);
      end
    end else begin
      e_valid[d] = 1'b0; e_wb[d] = 2'b00; e_mis[d] = 1'b0;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      wait_left[d] = 0;
      e_addr[d] = '0; e_data[d] = '0; e_wreg[d] = '0; e_wb[d] = '0;
      e_valid[d] = 1'b0; e_mis[d] = 1'b0;
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int d = 0; d < 2; d++) model_step(d);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got 0x%08h expected 0x%08h", name, d, $time, act, want);
    end
  endtask

  // Every cycle, away from the active edge, compare both instances to the model
  initial begin
    @(negedge clk);
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("address_out",    d, addr_o[d],          e_addr[d]);
        chk("data_out",       d, data_o[d],          e_data[d]);
        chk("writereg_out",   d, 32'(wreg_o[d]),     32'(e_wreg[d]));
        chk("wbcontrol_out",  d, 32'(wb_o[d]),       32'(e_wb[d]));
        chk("valid_out",      d, 32'(valid_o[d]),    32'(e_valid[d]));
        chk("misaligned_out", d, 32'(mis_o[d]),      32'(e_mis[d]));
        chk("membusy_out",    d, 32'(busy_o[d]),     32'(wait_left[d] > 0));
        chk("state_out",      d, 32'(st_o[d]),       32'(wait_left[d] > 0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int d, input logic v, input logic [31:0] a, input logic [31:0] wdat,
                       input logic [4:0] r, input logic [1:0] mc, input logic [1:0] wb);
    valid_in[d] = v; alu_in[d] = a; wd_in[d] = wdat; wreg_in[d] = r; mc_in[d] = mc; wb_in[d] = wb;
  endtask

  // Present one instruction for one edge, then wait (bounded) until the stage is free
  task automatic issue(input int d, input logic [31:0] a, input logic [31:0] wdat,
                       input logic [4:0] r, input logic [1:0] mc, input logic [1:0] wb);
    int n;
    @(negedge clk);
    drive(d, 1'b1, a, wdat, r, mc, wb);
    @(negedge clk);
    valid_in[d] = 1'b0;
    n = 0;
    while (busy_o[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy_o[d]) chk("busy_timeout", d, 32'(busy_o[d]), 32'd0);
  endtask

  // Check a DUT output and the model against the same hand-computed value
  task automatic lit(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] mdl, input logic [31:0] want);
    chk(name, d, act, want);
    chk({name, "_model"}, d, mdl, want);
  endtask

  task automatic fill(input int d);
    for (int i = 0; i < 256; i++) issue(d, 32'(i * 4), $urandom, 5'd0, 2'b01, 2'b00);
  endtask

  task automatic rand_drive(input int d, input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a = $urandom;
      if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
      drive(d, ($urandom_range(0, 9) < 7), a, $urandom, 5'($urandom_range(0, 31)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) drive(d, 1'b0, 32'd0, 32'd0, 5'd0, 2'b00, 2'b00);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset with a valid instruction in flight
    @(negedge clk);
    for (int d = 0; d < 2; d++) drive(d, 1'b1, 32'hCAFE_0004, 32'd0, 5'd7, 2'b00, 2'b01);
    @(posedge clk);
    #2;
    for (int d = 0; d < 2; d++) chk("pre_reset_valid", d, 32'(valid_o[d]), 32'd1);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_address", d, addr_o[d], 32'd0);
      chk("rst_valid",   d, 32'(valid_o[d]), 32'd0);
      chk("rst_wb",      d, 32'(wb_o[d]), 32'd0);
      chk("rst_wreg",    d, 32'(wreg_o[d]), 32'd0);
      valid_in[d] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("busy_after_reset", d, 32'(busy_o[d]), 32'd0);

    // Single-cycle: store then load
    issue(0, 32'h10, 32'hDEAD_BEEF, 5'd0, 2'b01, 2'b00);
    issue(0, 32'h10, 32'd0, 5'd5, 2'b10, 2'b11);
    lit("l1_load_data", 0, data_o[0], e_data[0], 32'hDEAD_BEEF);
    lit("l1_load_addr", 0, addr_o[0], e_addr[0], 32'h10);
    lit("l1_load_wreg", 0, 32'(wreg_o[0]), 32'(e_wreg[0]), 32'd5);
    lit("l1_load_wb",   0, 32'(wb_o[0]), 32'(e_wb[0]), 32'h3);
    lit("l1_load_valid", 0, 32'(valid_o[0]), 32'(e_valid[0]), 32'd1);

    // Pass-through
    issue(0, 32'h1234, 32'hFFFF_FFFF, 5'd3, 2'b00, 2'b01);
    lit("pass_addr", 0, addr_o[0], e_addr[0], 32'h1234);
    lit("pass_data", 0, data_o[0], e_data[0], 32'd0);
    lit("pass_wb",   0, 32'(wb_o[0]), 32'(e_wb[0]), 32'h1);

    // Misaligned load and store are suppressed
    issue(0, 32'h13, 32'd0, 5'd6, 2'b10, 2'b11);
    lit("mis_flag", 0, 32'(mis_o[0]), 32'(e_mis[0]), 32'd1);
    lit("mis_wb",   0, 32'(wb_o[0]), 32'(e_wb[0]), 32'h2);
    lit("mis_data", 0, data_o[0], e_data[0], 32'd0);
    issue(0, 32'h13, 32'h0000_0BAD, 5'd0, 2'b01, 2'b00);
    issue(0, 32'h10, 32'd0, 5'd5, 2'b10, 2'b11);
    lit("mis_ram_intact", 0, data_o[0], e_data[0], 32'hDEAD_BEEF);

    // Three-cycle: store then load with timing checks
    issue(1, 32'h20, 32'hA5A5_A5A5, 5'd0, 2'b01, 2'b00);
    @(negedge clk);
    drive(1, 1'b1, 32'h20, 32'd0, 5'd9, 2'b10, 2'b11);
    @(negedge clk);
    valid_in[1] = 1'b0;
    lit("l3_accept_valid", 1, 32'(valid_o[1]), 32'(e_valid[1]), 32'd0);
    chk("l3_accept_busy", 1, 32'(busy_o[1]), 32'd1);
    @(negedge clk);
    chk("l3_mid_busy", 1, 32'(busy_o[1]), 32'd1);
    @(negedge clk);
    chk("l3_done_busy", 1, 32'(busy_o[1]), 32'd0);
    lit("l3_load_valid", 1, 32'(valid_o[1]), 32'(e_valid[1]), 32'd1);
    lit("l3_load_data",  1, data_o[1], e_data[1], 32'hA5A5_A5A5);

    // Address aliasing
    issue(1, 32'h400, 32'h11, 5'd0, 2'b01, 2'b00);
    issue(1, 32'h000, 32'd0, 5'd2, 2'b10, 2'b11);
    lit("alias_data", 1, data_o[1], e_data[1], 32'h11);

    // Reset during ACCESS aborts the store
    @(negedge clk);
    drive(1, 1'b1, 32'h000, 32'h22, 5'd0, 2'b01, 2'b00);
    @(negedge clk);
    valid_in[1] = 1'b0;
    chk("abort_busy_before", 1, 32'(busy_o[1]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy_reset", 1, 32'(busy_o[1]), 32'd0);
    chk("abort_valid_reset", 1, 32'(valid_o[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(1, 32'h000, 32'd0, 5'd2, 2'b10, 2'b11);
    lit("abort_data", 1, data_o[1], e_data[1], 32'h11);

    // Give every RAM word a known value, then random traffic
    fork
      fill(0);
      fill(1);
    join
    fork
      rand_drive(0, 1500);
      rand_drive(1, 1500);
    join
    @(negedge clk);
    for (int d = 0; d < 2; d++) valid_in[d] = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
